// File: rtl/ram_port_scheduler.sv
// Four-phase pipeline sequencer and single-port RAM arbiter with external slot lending.
// Define RAM_SCHED_STALL_EN to add the starvation counter and one-cycle STALL insertion.
module ram_port_scheduler #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  clk_stage,
    output logic [3:0]  stage_en,
    output logic        stall,
    input  logic        s0_req,
    input  logic        s1_req,
    input  logic        s2_req,
    input  logic        s3_req,
    input  logic [15:0] s0_address,
    input  logic [15:0] s1_address,
    input  logic [15:0] s2_address,
    input  logic [15:0] s3_address,
    input  logic        s3_write,
    input  logic [31:0] s3_data,
    input  logic        ext_req,
    input  logic        ext_write,
    input  logic [15:0] ext_address,
    input  logic [31:0] ext_data,
    output logic        ext_grant,
    output logic [31:0] ext_rdata,
    output logic        ext_rdata_valid,
    output logic [15:0] ram_address,
    output logic [31:0] ram_in,
    output logic        ram_is_write,
    input  logic [31:0] ram_value
);

    localparam int unsigned CNT_MAX = 15;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > CNT_MAX) begin : g_limit_check
        $error("ram_port_scheduler: STARVE_LIMIT must be in 1..15");
    end

    logic [1:0]  phase_next;
    logic [3:0]  stage_req_vec;
    logic        stage_req;
    logic [15:0] stage_addr;
    logic        ext_own;
    logic        in_stall;

`ifdef RAM_SCHED_STALL_EN
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_next;

    assign in_stall = (state == STALL);
`else
    assign in_stall = 1'b0;
`endif

    assign stall = in_stall;

    // Address and request of the stage that owns the current phase
    assign stage_req_vec = {s3_req, s2_req, s1_req, s0_req};
    assign stage_req     = stage_req_vec[clk_stage];

    always_comb begin
        case (clk_stage)
            2'd0:    stage_addr = s0_address;
            2'd1:    stage_addr = s1_address;
            2'd2:    stage_addr = s2_address;
            default: stage_addr = s3_address;
        endcase
    end

    // Slot ownership, RAM port mux and next-state; reset forces the port idle immediately
    always_comb begin
        phase_next   = clk_stage;
        stage_en     = 4'b0000;
        ext_own      = 1'b0;
        ext_grant    = 1'b0;
        ram_address  = stage_addr;
        ram_in       = s3_data;
        ram_is_write = 1'b0;
`ifdef RAM_SCHED_STALL_EN
        state_next   = state;
        wait_next    = '0;
`endif
        if (!reset) begin
            if (in_stall) begin
                ext_own = ext_req;
            end else begin
                stage_en   = 4'b0001 << clk_stage;
                phase_next = clk_stage + 2'd1;
                if (stage_req) begin
                    ram_is_write = (clk_stage == 2'd3) && s3_write;
                end else begin
                    ext_own = ext_req;
                end
            end
            if (ext_own) begin
                ext_grant    = 1'b1;
                ram_address  = ext_address;
                ram_in       = ext_data;
                ram_is_write = ext_write;
            end
        end
`ifdef RAM_SCHED_STALL_EN
        if (ext_req && !ext_grant) begin
            wait_next = (wait_cnt == CNT_W'(CNT_MAX)) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
        case (state)
            RUN:     if (wait_next == CNT_W'(STARVE_LIMIT)) state_next = STALL;
            STALL:   state_next = RUN;
            default: state_next = RUN;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_stage       <= 2'd0;
            ext_rdata       <= 32'd0;
            ext_rdata_valid <= 1'b0;
`ifdef RAM_SCHED_STALL_EN
            state           <= RUN;
            wait_cnt        <= '0;
`endif
        end else begin
            clk_stage       <= phase_next;
            ext_rdata_valid <= ext_grant && !ext_write;
            if (ext_grant && !ext_write) begin
                ext_rdata <= ram_value;
            end
`ifdef RAM_SCHED_STALL_EN
            state           <= state_next;
            wait_cnt        <= wait_next;
`endif
        end
    end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Self-checking bench for ram_port_scheduler: directed test-plan scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_ram_port_scheduler;

    localparam int unsigned LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  clk_stage;
    logic [3:0]  stage_en;
    logic        stall;
    logic        s0_req, s1_req, s2_req, s3_req;
    logic [15:0] s0_address, s1_address, s2_address, s3_address;
    logic        s3_write;
    logic [31:0] s3_data;
    logic        ext_req, ext_write;
    logic [15:0] ext_address;
    logic [31:0] ext_data;
    logic        ext_grant;
    logic [31:0] ext_rdata;
    logic        ext_rdata_valid;
    logic [15:0] ram_address;
    logic [31:0] ram_in;
    logic        ram_is_write;
    logic [31:0] ram_value;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_phase;
    bit          m_stalled;
    int          m_wait;
    logic [31:0] m_rdata;
    logic        m_valid;

    // Model expectations for the current cycle
    logic [3:0]  e_stage_en;
    logic [15:0] e_addr;
    logic [31:0] e_in;
    logic        e_wr, e_grant, e_stall;

    ram_port_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .clk_stage(clk_stage), .stage_en(stage_en), .stall(stall),
        .s0_req(s0_req), .s1_req(s1_req), .s2_req(s2_req), .s3_req(s3_req),
        .s0_address(s0_address), .s1_address(s1_address),
        .s2_address(s2_address), .s3_address(s3_address),
        .s3_write(s3_write), .s3_data(s3_data),
        .ext_req(ext_req), .ext_write(ext_write),
        .ext_address(ext_address), .ext_data(ext_data),
        .ext_grant(ext_grant), .ext_rdata(ext_rdata), .ext_rdata_valid(ext_rdata_valid),
        .ram_address(ram_address), .ram_in(ram_in), .ram_is_write(ram_is_write),
        .ram_value(ram_value)
    );

    always #5 clk = ~clk;

    // Read-only RAM image: fixed content at 0x0100, hashed elsewhere
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0100) return 32'h12345678;
        return {a, ~a} ^ 32'h5A5A_0F0F;
    endfunction

    assign ram_value = mem_word(ram_address);

    task automatic idle_inputs();
        s0_req = 0; s1_req = 0; s2_req = 0; s3_req = 0;
        s0_address = 16'h1000; s1_address = 16'h1001; s2_address = 16'h1002; s3_address = 16'h1003;
        s3_write = 0; s3_data = 32'h0;
        ext_req = 0; ext_write = 0; ext_address = 16'h0; ext_data = 32'h0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_stalled = 0; m_wait = 0; m_rdata = 32'h0; m_valid = 0;
    endtask

    // Slot ownership from the priority rules: stall -> external, stage request, idle -> external
    task automatic model_expect();
        logic [3:0]  sr;
        logic [15:0] sa [4];
        bit          ext_own, stage_own;
        sr = {s3_req, s2_req, s1_req, s0_req};
        sa[0] = s0_address; sa[1] = s1_address; sa[2] = s2_address; sa[3] = s3_address;
        ext_own = 0; stage_own = 0;
        if (m_stalled)        ext_own = ext_req;
        else if (sr[m_phase]) stage_own = 1;
        else                  ext_own = ext_req;
        e_stall    = m_stalled;
        e_stage_en = m_stalled ? 4'b0000 : 4'(1 << m_phase);
        e_grant    = ext_own;
        e_addr     = ext_own ? ext_address : sa[m_phase];
        e_in       = ext_own ? ext_data : s3_data;
        e_wr       = (ext_own && ext_write) || (stage_own && m_phase == 3 && s3_write);
    endtask

    // Advance one clock edge and the model with it
    task automatic cycle();
        model_expect();
        @(posedge clk);
        if (e_grant && !ext_write) begin
            m_rdata = mem_word(e_addr);
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
`ifdef RAM_SCHED_STALL_EN
        if (ext_req && !e_grant) m_wait = (m_wait == 15) ? 15 : m_wait + 1;
        else                     m_wait = 0;
        if (m_stalled) begin
            m_stalled = 0;
        end else begin
            m_phase = (m_phase + 1) % 4;
            if (m_wait == int'(LIMIT)) m_stalled = 1;
        end
`else
        m_phase = (m_phase + 1) % 4;
`endif
        #1;
    endtask

    task automatic advance_to(input int p);
        idle_inputs();
        for (int i = 0; i < 8 && m_phase != p; i++) cycle();
    endtask

    task automatic test_reset();
        logic [3:0] exp_en [5];
        exp_en[0] = 4'b0001; exp_en[1] = 4'b0010; exp_en[2] = 4'b0100;
        exp_en[3] = 4'b1000; exp_en[4] = 4'b0001;
        reset = 1;
        idle_inputs();
        ext_req = 1; ext_write = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (clk_stage !== 2'd0 || stage_en !== 4'b0000 || stall !== 1'b0 || ext_grant !== 1'b0 ||
            ram_is_write !== 1'b0 || ext_rdata !== 32'h0 || ext_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got stage=%0d en=%b stall=%b grant=%b wr=%b rdata=%h valid=%b, expected all zero",
                     clk_stage, stage_en, stall, ext_grant, ram_is_write, ext_rdata, ext_rdata_valid);
        end
        idle_inputs();
        @(posedge clk);
        #1 reset = 0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (clk_stage !== 2'(i % 4) || stage_en !== exp_en[i] || ram_is_write !== 1'b0) begin
                errors++;
                $display("FAIL reset_sequence[%0d]: got stage=%0d en=%b wr=%b, expected stage=%0d en=%b wr=0",
                         i, clk_stage, stage_en, ram_is_write, i % 4, exp_en[i]);
            end
            cycle();
        end
    endtask

    task automatic test_s3_write();
        advance_to(3);
        s3_req = 1; s3_write = 1; s3_address = 16'h0040; s3_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (ram_is_write !== 1'b1 || ram_address !== 16'h0040 || ram_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL s3_write_phase3: got wr=%b addr=%h in=%h, expected wr=1 addr=0040 in=deadbeef",
                     ram_is_write, ram_address, ram_in);
        end
        cycle();
        advance_to(1);
        s3_req = 1; s3_write = 1; s3_address = 16'h0040; s3_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (ram_is_write !== 1'b0) begin
            errors++;
            $display("FAIL s3_write_phase1: got wr=%b expected 0", ram_is_write);
        end
        cycle();
        advance_to(3);
        s3_req = 0; s3_write = 1; s3_data = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (ram_is_write !== 1'b0) begin
            errors++;
            $display("FAIL s3_write_no_req: got wr=%b expected 0", ram_is_write);
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_ext_read();
        advance_to(1);
        s1_req = 0; ext_req = 1; ext_write = 0; ext_address = 16'h0100;
        @(negedge clk);
        checks++;
        if (ext_grant !== 1'b1 || ram_address !== 16'h0100 || ram_is_write !== 1'b0 || clk_stage !== 2'd1) begin
            errors++;
            $display("FAIL ext_read_grant: got grant=%b addr=%h wr=%b stage=%0d, expected grant=1 addr=0100 wr=0 stage=1",
                     ext_grant, ram_address, ram_is_write, clk_stage);
        end
        cycle();
        ext_req = 0;
        @(negedge clk);
        checks++;
        if (ext_rdata !== 32'h12345678 || ext_rdata_valid !== 1'b1) begin
            errors++;
            $display("FAIL ext_read_data: got rdata=%h valid=%b, expected 12345678 valid=1", ext_rdata, ext_rdata_valid);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (ext_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL ext_read_valid_pulse: got valid=%b expected 0", ext_rdata_valid);
        end
        cycle();
    endtask

    task automatic test_starvation();
        int grant_at;
`ifdef RAM_SCHED_STALL_EN
        logic [1:0] stall_phase;
        stall_phase = 2'd0;
`endif
        idle_inputs();
        s0_req = 1; s1_req = 1; s2_req = 1; s3_req = 1;
        ext_req = 1; ext_write = 0; ext_address = 16'h0222;
        grant_at = 0;
        for (int i = 1; i <= 40 && grant_at == 0; i++) begin
            @(negedge clk);
            if (ext_grant === 1'b1) begin
                grant_at = i;
`ifdef RAM_SCHED_STALL_EN
                stall_phase = clk_stage;
                checks++;
                if (stall !== 1'b1 || stage_en !== 4'b0000) begin
                    errors++;
                    $display("FAIL starve_stall_cycle: got stall=%b en=%b, expected stall=1 en=0000", stall, stage_en);
                end
`endif
            end
            cycle();
        end
        idle_inputs();
`ifdef RAM_SCHED_STALL_EN
        checks++;
        if (grant_at != int'(LIMIT) + 1) begin
            errors++;
            $display("FAIL starve_grant_cycle: got cycle %0d expected %0d", grant_at, LIMIT + 1);
        end
        @(negedge clk);
        checks++;
        if (clk_stage !== stall_phase || stage_en !== 4'(1 << stall_phase) || stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_resume: got stage=%0d en=%b stall=%b, expected stage=%0d stall=0",
                     clk_stage, stage_en, stall, stall_phase);
        end
        cycle();
`else
        checks++;
        if (grant_at != 0) begin
            errors++;
            $display("FAIL starve_no_grant: got grant at cycle %0d expected none", grant_at);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            s0_req = ($urandom_range(0, 9) < 6);
            s1_req = ($urandom_range(0, 9) < 6);
            s2_req = ($urandom_range(0, 9) < 6);
            s3_req = ($urandom_range(0, 9) < 6);
            s0_address = 16'($urandom); s1_address = 16'($urandom);
            s2_address = 16'($urandom); s3_address = 16'($urandom);
            s3_write = 1'($urandom_range(0, 1)); s3_data = $urandom;
            if (!ext_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    ext_req = 1; ext_write = 1'($urandom_range(0, 1));
                    ext_address = 16'($urandom); ext_data = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ext_req = 0;
            end
            @(negedge clk);
            model_expect();
            checks++; if (clk_stage !== 2'(m_phase)) begin errors++; $display("FAIL rnd_clk_stage[%0d]: got %0d expected %0d", n, clk_stage, m_phase); end
            checks++; if (stage_en !== e_stage_en) begin errors++; $display("FAIL rnd_stage_en[%0d]: got %b expected %b", n, stage_en, e_stage_en); end
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, stall, e_stall); end
            checks++; if (ext_grant !== e_grant) begin errors++; $display("FAIL rnd_ext_grant[%0d]: got %b expected %b", n, ext_grant, e_grant); end
            checks++; if (ram_address !== e_addr) begin errors++; $display("FAIL rnd_ram_address[%0d]: got %h expected %h", n, ram_address, e_addr); end
            checks++; if (ram_in !== e_in) begin errors++; $display("FAIL rnd_ram_in[%0d]: got %h expected %h", n, ram_in, e_in); end
            checks++; if (ram_is_write !== e_wr) begin errors++; $display("FAIL rnd_ram_is_write[%0d]: got %b expected %b", n, ram_is_write, e_wr); end
            checks++; if (ext_rdata !== m_rdata) begin errors++; $display("FAIL rnd_ext_rdata[%0d]: got %h expected %h", n, ext_rdata, m_rdata); end
            checks++; if (ext_rdata_valid !== m_valid) begin errors++; $display("FAIL rnd_ext_rdata_valid[%0d]: got %b expected %b", n, ext_rdata_valid, m_valid); end
            cycle();
            if (e_grant) ext_req = 0;
        end
        idle_inputs();
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ext_req = 1; ext_write = 0; ext_address = 16'h0100;
        @(negedge clk);
        checks++;
        if (ext_grant !== 1'b1) begin
            errors++;
            $display("FAIL midrst_read_grant: got %b expected 1", ext_grant);
        end
        cycle();
        ext_req = 1; ext_write = 1; ext_address = 16'h0300; ext_data = 32'hCAFE_0001;
        @(negedge clk);
        checks++;
        if (ram_is_write !== 1'b1 || ext_grant !== 1'b1 || ext_rdata_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_write_setup: got wr=%b grant=%b valid=%b, expected 1 1 1",
                     ram_is_write, ext_grant, ext_rdata_valid);
        end
        #1 reset = 1;
        #1;
        checks++;
        if (ram_is_write !== 1'b0 || ext_grant !== 1'b0 || ext_rdata_valid !== 1'b0 ||
            clk_stage !== 2'd0 || stage_en !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: got wr=%b grant=%b valid=%b stage=%0d en=%b, expected all zero",
                     ram_is_write, ext_grant, ext_rdata_valid, clk_stage, stage_en);
        end
        @(posedge clk);
        #1 reset = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        checks++;
        if (clk_stage !== 2'd0 || stage_en !== 4'b0001 || ext_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_restart: got stage=%0d en=%b valid=%b, expected 0 0001 0",
                     clk_stage, stage_en, ext_rdata_valid);
        end
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_s3_write();
        test_ext_read();
        test_starvation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_port_scheduler.md
# ram_port_scheduler

Four-phase pipeline sequencer and single-port RAM arbiter for the 32-bit/16-bit-address core. It generates the `clk_stage` phase and per-stage enables, routes each phase's RAM request (fetch, operand read, ALU read, writeback) onto the one RAM port, and lends idle slots to an external requester such as a boot loader or debug port. An optional starvation guard inserts one-cycle pipeline stalls so the external requester always makes progress.

## Interface
- `STARVE_LIMIT`, default 8: consecutive ungranted `ext_req` cycles before a stall is forced; legal range 1..15.

- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `clk_stage`  out  2  current pipeline phase 0..3
- `stage_en`  out  4  one-hot stage advance; bit p = phase p
- `stall`  out  1  high during an inserted stall cycle
- `s0_req`,`s1_req`,`s2_req`,`s3_req`  in  1 each  stage p wants RAM in its phase
- `s0_address`..`s3_address`  in  16 each  stage RAM address
- `s3_write`  in  1  stage-3 access is a write
- `s3_data`  in  32  stage-3 write data
- `ext_req`  in  1  external request; held until granted
- `ext_write`  in  1  external access is a write
- `ext_address`  in  16  external address
- `ext_data`  in  32  external write data
- `ext_grant`  out  1  external access is performed at this rising edge
- `ext_rdata`  out  32  registered external read data
- `ext_rdata_valid`  out  1  one-cycle pulse when `ext_rdata` is updated
- `ram_address`  out  16  to RAM
- `ram_in`  out  32  to RAM write data
- `ram_is_write`  out  1  to RAM write enable
- `ram_value`  in  32  RAM combinational read data

## Operation
- Phase counter `clk_stage` increments mod 4 (3→0) each cycle unless the cycle is a stall.
- `stage_en` = one-hot of `clk_stage` in RUN; 4'b0000 during STALL and during reset.
- Slot owner per cycle, in priority order:
  - STALL: external (`ext_grant`=1).
  - RUN and `s<p>_req`: stage p; `ram_address`=`s<p>_address`.
  - RUN, no stage request, `ext_req`: external, idle slot.
  - Otherwise: no owner; `ram_address`=`s<p>_address`, no write.
- Writes: `ram_is_write`=1 only when (phase 3 owner, `s3_req`, `s3_write`) or (external owner, `ext_write`). Stages 0–2 are read-only; `s3_write` without `s3_req` is ignored. `ram_in` = `s3_data` or `ext_data` accordingly; otherwise it holds `s3_data`.
- External read: on a granted edge with `ext_write`=0, `ram_value` is captured into `ext_rdata`, and `ext_rdata_valid` is high for the following cycle. External writes do not pulse valid.
- Starvation counter `wait_cnt` (4 bits): increments on each edge where `ext_req`=1 and `ext_grant`=0, saturating at 15. It clears on a grant or when `ext_req`=0.
- FSM:
  - RUN→STALL when `wait_cnt` reaches `STARVE_LIMIT` on that edge.
  - STALL→RUN unconditionally after one cycle.
  - A stall may start in any phase; the phase resumes unchanged.

## Timing
- Reset values: `clk_stage`=0, `stage_en`=0000, `stall`=0, `ext_grant`=0, `ram_is_write`=0, `ext_rdata`=0, `ext_rdata_valid`=0, `wait_cnt`=0, FSM=RUN.
- First cycle after reset release: phase 0, `stage_en`=0001.
- `ram_address`, `ram_in`, `ram_is_write`, `ext_grant` and `stage_en` are combinational from the registered phase/FSM and the current requests. All other state is registered.
- External read latency: data valid 1 cycle after the grant edge.
- Worst-case external wait with the stall guard: `STARVE_LIMIT`+1 cycles from `ext_req` rise to grant.
- If `ext_req` drops before a grant, no access occurs and `wait_cnt` clears.
- Reset asserted mid-operation: in-flight external access is aborted, no write occurs, and valid is cleared immediately (asynchronous).

## Configuration
- `RAM_SCHED_STALL_EN` defined: starvation counter and STALL state are present as described.
- Not defined: no counter and no STALL state. `stall` is tied 0, the phase advances every cycle, and the external requester is served only in idle slots; it may starve indefinitely.

## Test plan
- Reset, then release with no requests: `clk_stage` sequences 0,1,2,3,0 and `stage_en` 0001,0010,0100,1000,0001; `ram_is_write`=0 throughout.
- `s3_req`=1, `s3_write`=1, `s3_address`=16'h0040, `s3_data`=32'hDEADBEEF in phase 3 → `ram_is_write`=1, `ram_address`=16'h0040, `ram_in`=32'hDEADBEEF; `s3_write` in phase 1 → no write.
- `s1_req`=0, `ext_req` read of 16'h0100 (RAM holds 32'h12345678) → `ext_grant` in phase 1; next cycle `ext_rdata`=32'h12345678 and `ext_rdata_valid`=1 for exactly one cycle.
- With `RAM_SCHED_STALL_EN` and `STARVE_LIMIT`=3, all `s*_req`=1, `ext_req` held → grant on the 4th cycle with `stall`=1 and `stage_en`=0000; the phase repeats after the stall; without the macro, no grant ever occurs.
- Assert `reset` during a granted external write cycle → `ram_is_write` falls immediately, `ext_rdata_valid`=0, and the phase restarts at 0.
